// File: rtl/aib_axi_ctrl_pkg.sv
// Shared types and constants for the AIB/AXI link bring-up sequencer.
// The o_state encoding constants are also used by the debug/CSR decoder.
package aib_axi_ctrl_pkg;

  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_CREDIT_W  = 8;
  localparam int unsigned DEF_MAX_RETRY = 3;

  localparam logic [2:0] ST_ENC_IDLE   = 3'd0;
  localparam logic [2:0] ST_ENC_SETTLE = 3'd1;
  localparam logic [2:0] ST_ENC_CONF   = 3'd2;
  localparam logic [2:0] ST_ENC_DELAY  = 3'd3;
  localparam logic [2:0] ST_ENC_ONLINE = 3'd4;
  localparam logic [2:0] ST_ENC_RETRY  = 3'd5;
  localparam logic [2:0] ST_ENC_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_ENC_IDLE,
    S_SETTLE = ST_ENC_SETTLE,
    S_CONF   = ST_ENC_CONF,
    S_DELAY  = ST_ENC_DELAY,
    S_ONLINE = ST_ENC_ONLINE,
    S_RETRY  = ST_ENC_RETRY,
    S_ERROR  = ST_ENC_ERROR
  } state_t;

endpackage

// File: rtl/aib_ctrl_dncnt.sv
// Loadable down-counter that saturates at zero; shared by the settle,
// timeout and delay phases of the link sequencer.
module aib_ctrl_dncnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/aib_axi_link_ctrl.sv
// Bring-up and recovery sequencer: waits for the AIB link, raises conf_done
// and initial credits, brings the AXI channels online, retries on link loss.
module aib_axi_link_ctrl
  import aib_axi_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned CREDIT_W  = DEF_CREDIT_W,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                i_enable,
  input  logic [CNT_W-1:0]    i_cfg_settle,
  input  logic [CNT_W-1:0]    i_cfg_timeout,
  input  logic [CNT_W-1:0]    i_cfg_delay,
  input  logic [CREDIT_W-1:0] i_cfg_credit,
  input  logic                i_device_detect,
  input  logic                i_link_ready,
  output logic                o_conf_done,
  output logic                o_tx_online,
  output logic                o_rx_online,
  output logic [CREDIT_W-1:0] o_init_credit,
  output logic                o_link_up,
  output logic                o_error,
  output logic [2:0]          o_retry_cnt,
  output logic [2:0]          o_state
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    sh_settle, sh_timeout, sh_delay;
  logic [CREDIT_W-1:0] sh_credit;
  logic [2:0]          retry_q;
  logic                cnt_load, cnt_zero, link_ok, cfg_phase;
  logic [CNT_W-1:0]    cnt_val;

  // Phases last max(n,1) cycles: load n-1 and leave on the zero flag.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign link_ok = i_device_detect & i_link_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (!i_enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_SETTLE;
          cnt_load = 1'b1;
          cnt_val  = sat_dec(i_cfg_settle);
        end
        S_SETTLE: begin
          if (cnt_zero) begin
            state_d  = S_CONF;
            cnt_load = 1'b1;
            cnt_val  = sat_dec(sh_timeout);
          end
        end
        S_CONF: begin
          if (link_ok) begin
            state_d  = S_DELAY;
            cnt_load = 1'b1;
            cnt_val  = sat_dec(sh_delay);
          end else if ((sh_timeout != '0) && cnt_zero) begin
            state_d = S_RETRY;
          end
        end
        S_DELAY: begin
          if (!link_ok)      state_d = S_RETRY;
          else if (cnt_zero) state_d = S_ONLINE;
        end
        S_ONLINE: begin
          if (!link_ok) state_d = S_RETRY;
        end
        S_RETRY: begin
          if (retry_q == 3'(MAX_RETRY)) begin
            state_d = S_ERROR;
          end else begin
            state_d  = S_SETTLE;
            cnt_load = 1'b1;
            cnt_val  = sat_dec(sh_settle);
          end
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  aib_ctrl_dncnt #(.CNT_W(CNT_W)) u_dncnt (
    .clk_wr   (clk_wr),
    .rst_wr   (rst_wr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (~cnt_load),
    .zero     (cnt_zero)
  );

  assign cfg_phase = (state_d == S_CONF) || (state_d == S_DELAY) ||
                     (state_d == S_ONLINE);

  // Outputs are decoded from the next state so they change on the same edge
  // as state_q and carry no combinational path from the inputs.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q       <= S_IDLE;
      sh_settle     <= '0;
      sh_timeout    <= '0;
      sh_delay      <= '0;
      sh_credit     <= '0;
      retry_q       <= '0;
      o_conf_done   <= 1'b0;
      o_tx_online   <= 1'b0;
      o_rx_online   <= 1'b0;
      o_init_credit <= '0;
      o_link_up     <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && i_enable) begin
        sh_settle  <= i_cfg_settle;
        sh_timeout <= i_cfg_timeout;
        sh_delay   <= i_cfg_delay;
        sh_credit  <= i_cfg_credit;
      end
      if ((state_d == S_IDLE) || (state_d == S_ONLINE)) retry_q <= '0;
      else if (state_d == S_RETRY)                       retry_q <= retry_q + 3'd1;
      o_conf_done   <= cfg_phase;
      o_init_credit <= cfg_phase ? sh_credit : '0;
      o_tx_online   <= (state_d == S_ONLINE);
      o_rx_online   <= (state_d == S_ONLINE);
      o_link_up     <= (state_d == S_ONLINE);
      o_error       <= (state_d == S_ERROR);
    end
  end

  assign o_retry_cnt = retry_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_aib_axi_link_ctrl.sv
// Directed bench for aib_axi_link_ctrl: bring-up, timeout/retry, link loss,
// zero configs, transition priorities and mid-operation reset.
module tb_aib_axi_link_ctrl;

  localparam int CNT_W    = 16;
  localparam int CREDIT_W = 8;

  logic                clk_wr = 1'b0;
  logic                rst_wr;
  logic                i_enable;
  logic [CNT_W-1:0]    i_cfg_settle, i_cfg_timeout, i_cfg_delay;
  logic [CREDIT_W-1:0] i_cfg_credit;
  logic                i_device_detect, i_link_ready;
  logic                o_conf_done, o_tx_online, o_rx_online, o_link_up, o_error;
  logic [CREDIT_W-1:0] o_init_credit;
  logic [2:0]          o_retry_cnt, o_state;

  int total = 0;
  int bad   = 0;

  aib_axi_link_ctrl #(.CNT_W(CNT_W), .CREDIT_W(CREDIT_W), .MAX_RETRY(3)) dut (
    .clk_wr          (clk_wr),
    .rst_wr          (rst_wr),
    .i_enable        (i_enable),
    .i_cfg_settle    (i_cfg_settle),
    .i_cfg_timeout   (i_cfg_timeout),
    .i_cfg_delay     (i_cfg_delay),
    .i_cfg_credit    (i_cfg_credit),
    .i_device_detect (i_device_detect),
    .i_link_ready    (i_link_ready),
    .o_conf_done     (o_conf_done),
    .o_tx_online     (o_tx_online),
    .o_rx_online     (o_rx_online),
    .o_init_credit   (o_init_credit),
    .o_link_up       (o_link_up),
    .o_error         (o_error),
    .o_retry_cnt     (o_retry_cnt),
    .o_state         (o_state)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_wr);
    @(negedge clk_wr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"},  32'(o_state), 0);
    check({tag, ".conf"},   32'(o_conf_done), 0);
    check({tag, ".tx"},     32'(o_tx_online), 0);
    check({tag, ".rx"},     32'(o_rx_online), 0);
    check({tag, ".credit"}, 32'(o_init_credit), 0);
    check({tag, ".up"},     32'(o_link_up), 0);
    check({tag, ".err"},    32'(o_error), 0);
    check({tag, ".retry"},  32'(o_retry_cnt), 0);
  endtask

  task automatic set_cfg(input int settle, input int tmo, input int dly, input int cr);
    i_cfg_settle  = CNT_W'(settle);
    i_cfg_timeout = CNT_W'(tmo);
    i_cfg_delay   = CNT_W'(dly);
    i_cfg_credit  = CREDIT_W'(cr);
  endtask

  initial begin
    rst_wr = 1'b1;
    i_enable = 1'b0;
    set_cfg(0, 0, 0, 0);
    i_device_detect = 1'b1;
    i_link_ready = 1'b1;
    tick(2);
    check_all_zero("por");
    rst_wr = 1'b0;
    tick(1);

    // Nominal bring-up: enable high during cycle 0 (IDLE).
    set_cfg(4, 0, 2, 8);
    i_enable = 1'b1;
    check("nom.c0_state", 32'(o_state), 0);
    tick(1);
    i_cfg_credit = 8'd5;  // must be ignored outside IDLE
    tick(3);
    check("nom.c4_state", 32'(o_state), 1);
    check("nom.c4_conf",  32'(o_conf_done), 0);
    tick(1);
    check("nom.c5_conf",   32'(o_conf_done), 1);
    check("nom.c5_credit", 32'(o_init_credit), 8);
    check("nom.c5_state",  32'(o_state), 2);
    tick(2);
    check("nom.c7_state", 32'(o_state), 3);
    check("nom.c7_tx",    32'(o_tx_online), 0);
    tick(1);
    check("nom.c8_tx",     32'(o_tx_online), 1);
    check("nom.c8_rx",     32'(o_rx_online), 1);
    check("nom.c8_up",     32'(o_link_up), 1);
    check("nom.c8_state",  32'(o_state), 4);
    check("nom.c8_credit", 32'(o_init_credit), 8);

    // Link loss for one cycle in ONLINE.
    i_link_ready = 1'b0;
    tick(1);
    check("loss.state",  32'(o_state), 5);
    check("loss.tx",     32'(o_tx_online), 0);
    check("loss.conf",   32'(o_conf_done), 0);
    check("loss.credit", 32'(o_init_credit), 0);
    check("loss.retry",  32'(o_retry_cnt), 1);
    i_link_ready = 1'b1;
    tick(1);
    check("loss.settle", 32'(o_state), 1);
    check("loss.retry2", 32'(o_retry_cnt), 1);
    tick(7);
    check("loss.online", 32'(o_state), 4);
    check("loss.tx2",    32'(o_tx_online), 1);
    check("loss.retry0", 32'(o_retry_cnt), 0);

    // Reset held three cycles while ONLINE.
    rst_wr = 1'b1;
    tick(1);
    check_all_zero("rst");
    tick(2);
    i_enable = 1'b0;
    rst_wr = 1'b0;
    tick(1);
    check("rst.idle", 32'(o_state), 0);

    // Timeout/retry to sticky error: CONF lasts 10 cycles, period 12.
    set_cfg(1, 10, 1, 3);
    i_link_ready = 1'b0;
    i_enable = 1'b1;
    tick(11);
    check("tmo.c11_conf", 32'(o_state), 2);
    tick(1);
    check("tmo.r1_state", 32'(o_state), 5);
    check("tmo.r1_cnt",   32'(o_retry_cnt), 1);
    tick(12);
    check("tmo.r2_state", 32'(o_state), 5);
    check("tmo.r2_cnt",   32'(o_retry_cnt), 2);
    tick(12);
    check("tmo.r3_state", 32'(o_state), 5);
    check("tmo.r3_cnt",   32'(o_retry_cnt), 3);
    tick(1);
    check("tmo.err_state", 32'(o_state), 6);
    check("tmo.err",       32'(o_error), 1);
    check("tmo.err_conf",  32'(o_conf_done), 0);
    tick(3);
    check("tmo.sticky", 32'(o_error), 1);
    i_enable = 1'b0;
    tick(1);
    check("tmo.idle",   32'(o_state), 0);
    check("tmo.clr",    32'(o_error), 0);
    check("tmo.clrcnt", 32'(o_retry_cnt), 0);

    // Zero configs: no timeout, one-cycle SETTLE and DELAY.
    set_cfg(0, 0, 0, 2);
    i_enable = 1'b1;
    tick(2);
    check("zero.conf", 32'(o_state), 2);
    tick(500);
    check("zero.wait_state", 32'(o_state), 2);
    check("zero.wait_conf",  32'(o_conf_done), 1);
    i_link_ready = 1'b1;
    tick(1);
    check("zero.delay",  32'(o_state), 3);
    check("zero.tx_lo",  32'(o_tx_online), 0);
    tick(1);
    check("zero.tx_hi",  32'(o_tx_online), 1);
    check("zero.credit", 32'(o_init_credit), 2);
    i_enable = 1'b0;
    tick(1);

    // Link arrives on the cycle the timeout counter reaches zero.
    set_cfg(1, 10, 1, 4);
    i_link_ready = 1'b0;
    i_enable = 1'b1;
    tick(11);
    i_link_ready = 1'b1;
    tick(1);
    check("prio.delay", 32'(o_state), 3);
    check("prio.retry", 32'(o_retry_cnt), 0);
    tick(1);
    check("prio.online", 32'(o_state), 4);

    // Disable and link loss in the same cycle: IDLE wins over RETRY.
    i_enable = 1'b0;
    i_link_ready = 1'b0;
    tick(1);
    check("prio.idle",  32'(o_state), 0);
    check("prio.rcnt",  32'(o_retry_cnt), 0);
    check("prio.tx",    32'(o_tx_online), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
